// File: rtl/sobel_mac_sequencer_pkg.sv
// Shared types and constants for the Sobel MAC sequencer.
// Kernels, tap count and FSM states live here.
package sobel_pkg;

  localparam int PIXEL_W_D = 8;
  localparam int ACC_W_D   = 16;
  localparam int TAPS      = 9;
  localparam int TAP_W     = 4;
  localparam int COEF_W    = 3;

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  // k = row*3 + col, k=0 is top-left
  localparam logic signed [COEF_W-1:0] GX_COEF [TAPS] = '{
    -3'sd1, 3'sd0, 3'sd1,
    -3'sd2, 3'sd0, 3'sd2,
    -3'sd1, 3'sd0, 3'sd1
  };

  localparam logic signed [COEF_W-1:0] GY_COEF [TAPS] = '{
    -3'sd1, -3'sd2, -3'sd1,
     3'sd0,  3'sd0,  3'sd0,
     3'sd1,  3'sd2,  3'sd1
  };

endpackage

// File: rtl/sobel_mac_sequencer_if.sv
// Window-in / gradient-out handshake bundle.
// master drives windows and ready_i; slave is the sequencer.
interface sobel_mac_sequencer_if
  import sobel_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_D,
  parameter int ACC_W   = ACC_W_D
);

  logic                      valid_i;
  logic                      ready_o;
  logic [TAPS*PIXEL_W-1:0]   window_i;
  logic                      valid_o;
  logic                      ready_i;
  logic signed [ACC_W-1:0]   gx_o;
  logic signed [ACC_W-1:0]   gy_o;
  logic [PIXEL_W-1:0]        mag_o;

  modport master (
    output valid_i, window_i, ready_i,
    input  ready_o, valid_o, gx_o, gy_o, mag_o
  );

  modport slave (
    input  valid_i, window_i, ready_i,
    output ready_o, valid_o, gx_o, gy_o, mag_o
  );

endinterface

// File: rtl/sobel_mac_lane.sv
// One signed accumulator lane: acc <= clr ? 0 : acc + pix*coef.
// sum_o is the value the register takes next edge.
module sobel_mac_lane
  import sobel_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_D,
  parameter int ACC_W   = ACC_W_D
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clr,
  input  logic                     en,
  input  logic [PIXEL_W-1:0]       pix,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] pix_s;
  logic signed [ACC_W-1:0] coef_s;
  logic signed [ACC_W-1:0] prod;

  assign pix_s  = signed'(ACC_W'(pix));
  assign coef_s = ACC_W'(coef);
  assign prod   = pix_s * coef_s;

  always_comb begin
    sum_o = acc_q;
    if (clr) begin
      sum_o = '0;
    end else if (en) begin
      sum_o = acc_q + prod;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/sobel_mac_sequencer.sv
// Sequences nine taps through two MAC lanes (Gx, Gy) and
// registers gradients plus saturated |gx|+|gy| for downstream.
module sobel_mac_sequencer
  import sobel_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_D,
  parameter int ACC_W   = ACC_W_D
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  sobel_mac_sequencer_if.slave  ifc
);

  state_t                  state_q, state_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic [PIXEL_W-1:0]      win_q [TAPS];
  logic                    rdy;
  logic                    accept;
  logic                    clr;
  logic                    en;
  logic                    ld;
  logic [PIXEL_W-1:0]      pix;
  logic signed [ACC_W-1:0] gx_nxt, gy_nxt;
  logic signed [ACC_W-1:0] gx_q, gy_q;
  logic [PIXEL_W-1:0]      mag_d, mag_q;
  logic signed [ACC_W:0]   gx_e, gy_e;
  logic [ACC_W:0]          ax, ay, asum;

  assign rdy    = (state_q == IDLE) && !reset_i;
  assign accept = ifc.valid_i && rdy;
  assign pix    = win_q[tap_q];

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    clr     = 1'b0;
    en      = 1'b0;
    ld      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          clr     = 1'b1;
          tap_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        en = 1'b1;
        if (tap_q == TAP_LAST) begin
          ld      = 1'b1;
          tap_d   = '0;
          state_d = DONE;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      DONE: begin
        if (ifc.ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < TAPS; k++) win_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < TAPS; k++) begin
        win_q[k] <= ifc.window_i[k*PIXEL_W +: PIXEL_W];
      end
    end
  end

  sobel_mac_lane #(.PIXEL_W(PIXEL_W), .ACC_W(ACC_W)) u_gx (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr     (clr),
    .en      (en),
    .pix     (pix),
    .coef    (GX_COEF[tap_q]),
    .sum_o   (gx_nxt)
  );

  sobel_mac_lane #(.PIXEL_W(PIXEL_W), .ACC_W(ACC_W)) u_gy (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr     (clr),
    .en      (en),
    .pix     (pix),
    .coef    (GY_COEF[tap_q]),
    .sum_o   (gy_nxt)
  );

  // magnitude taken from the final sums so results land with the last tap
  assign gx_e = (ACC_W+1)'(gx_nxt);
  assign gy_e = (ACC_W+1)'(gy_nxt);
  assign ax   = gx_e[ACC_W] ? -gx_e : gx_e;
  assign ay   = gy_e[ACC_W] ? -gy_e : gy_e;
  assign asum = ax + ay;
  assign mag_d = (|asum[ACC_W:PIXEL_W]) ? '1 : asum[PIXEL_W-1:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      gx_q  <= '0;
      gy_q  <= '0;
      mag_q <= '0;
    end else if (ld) begin
      gx_q  <= gx_nxt;
      gy_q  <= gy_nxt;
      mag_q <= mag_d;
    end
  end

  assign ifc.ready_o = rdy;
  assign ifc.valid_o = (state_q == DONE);
  assign ifc.gx_o    = gx_q;
  assign ifc.gy_o    = gy_q;
  assign ifc.mag_o   = mag_q;

endmodule

// File: tb/tb_sobel_mac_sequencer.sv
// Scoreboard bench for sobel_mac_sequencer: expected gradients
// are queued at accept and compared when results are presented.
module tb_sobel_mac_sequencer;

  localparam int PW = 8;
  localparam int AW = 16;

  typedef struct {
    int gx;
    int gy;
    int mag;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  res_t exp_q[$];

  int kx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int ky [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  sobel_mac_sequencer_if #(.PIXEL_W(PW), .ACC_W(AW)) ifc ();

  sobel_mac_sequencer #(.PIXEL_W(PW), .ACC_W(AW)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .ifc     (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9*PW-1:0] mk_win(input int v[9]);
    logic [9*PW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(v[k]);
    return w;
  endfunction

  function automatic res_t model(input logic [9*PW-1:0] w);
    res_t r;
    int p, s;
    r.gx = 0;
    r.gy = 0;
    for (int k = 0; k < 9; k++) begin
      p = int'(w[k*PW +: PW]);
      r.gx += p * kx[k];
      r.gy += p * ky[k];
    end
    s = (r.gx < 0 ? -r.gx : r.gx) + (r.gy < 0 ? -r.gy : r.gy);
    r.mag = (s > 255) ? 255 : s;
    return r;
  endfunction

  task automatic send(input string name, input logic [9*PW-1:0] w,
                      input bit drop, output int acc, output bit ok);
    ok = 1'b0;
    acc = -1;
    ifc.valid_i  = 1'b1;
    ifc.window_i = w;
    for (int i = 0; i < 60; i++) begin
      if (ifc.ready_o) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok = 1'b1;
        exp_q.push_back(model(w));
        break;
      end
      @(posedge clk);
      #1;
    end
    if (drop) ifc.valid_i = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s accept: ready_o never seen", name);
    end
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ifc.valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s valid: valid_o timeout", name);
    end
  endtask

  task automatic run_one(input string name, input logic [9*PW-1:0] w);
    int acc;
    bit ok;
    res_t e;
    send(name, w, 1'b1, acc, ok);
    if (!ok) return;
    wait_valid(name, ok);
    if (!ok) return;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: result with empty queue", name);
      return;
    end
    e = exp_q.pop_front();
    if ($signed(ifc.gx_o) !== e.gx) begin
      fails++;
      $display("FAIL %s gx: got %0d want %0d", name, $signed(ifc.gx_o), e.gx);
    end
    tests++;
    if ($signed(ifc.gy_o) !== e.gy) begin
      fails++;
      $display("FAIL %s gy: got %0d want %0d", name, $signed(ifc.gy_o), e.gy);
    end
    tests++;
    if (int'(ifc.mag_o) !== e.mag) begin
      fails++;
      $display("FAIL %s mag: got %0d want %0d", name, ifc.mag_o, e.mag);
    end
    ifc.ready_i = 1'b1;
    @(posedge clk);
    #1;
    ifc.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (ifc.ready_o !== 1'b0) begin
      fails++;
      $display("FAIL reset ready_o: got %b want 0", ifc.ready_o);
    end
    tests++;
    if (ifc.valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset valid_o: got %b want 0", ifc.valid_o);
    end
    tests++;
    if (ifc.gx_o !== '0 || ifc.gy_o !== '0 || ifc.mag_o !== '0) begin
      fails++;
      $display("FAIL reset outputs: got %0d/%0d/%0d want 0/0/0",
               ifc.gx_o, ifc.gy_o, ifc.mag_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (ifc.ready_o !== 1'b1) begin
      fails++;
      $display("FAIL release ready_o: got %b want 1", ifc.ready_o);
    end
  endtask

  task automatic test_latency();
    int acc;
    bit ok;
    res_t e;
    send("latency", mk_win('{100, 100, 100, 100, 100, 100, 100, 100, 100}),
         1'b1, acc, ok);
    if (!ok) return;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      #1;
      if (n == 8) begin
        tests++;
        if (ifc.valid_o !== 1'b0 || ifc.ready_o !== 1'b0) begin
          fails++;
          $display("FAIL latency early: valid_o=%b ready_o=%b want 0/0",
                   ifc.valid_o, ifc.ready_o);
        end
      end
    end
    tests++;
    if (ifc.valid_o !== 1'b1) begin
      fails++;
      $display("FAIL latency edge: valid_o=%b want 1", ifc.valid_o);
      return;
    end
    e = exp_q.pop_front();
    tests++;
    if ($signed(ifc.gx_o) !== e.gx || $signed(ifc.gy_o) !== e.gy ||
        int'(ifc.mag_o) !== e.mag) begin
      fails++;
      $display("FAIL latency result: got %0d/%0d/%0d want %0d/%0d/%0d",
               $signed(ifc.gx_o), $signed(ifc.gy_o), ifc.mag_o,
               e.gx, e.gy, e.mag);
    end
    ifc.ready_i = 1'b1;
    @(posedge clk);
    #1;
    ifc.ready_i = 1'b0;
    tests++;
    if (ifc.valid_o !== 1'b0) begin
      fails++;
      $display("FAIL latency drop: valid_o=%b want 0", ifc.valid_o);
    end
  endtask

  task automatic test_patterns();
    run_one("right_col", mk_win('{0, 0, 255, 0, 0, 255, 0, 0, 255}));
    run_one("top_row", mk_win('{200, 200, 200, 0, 0, 0, 0, 0, 0}));
    run_one("tap5", mk_win('{0, 0, 0, 0, 0, 10, 0, 0, 0}));
  endtask

  task automatic test_backpressure();
    int acc;
    bit ok;
    res_t e;
    logic [AW-1:0] gx0, gy0;
    logic [PW-1:0] mg0;
    logic [9*PW-1:0] wb;
    send("bp_a", mk_win('{9, 0, 0, 30, 0, 0, 0, 0, 70}), 1'b1, acc, ok);
    if (!ok) return;
    wait_valid("bp_a", ok);
    if (!ok) return;
    gx0 = ifc.gx_o;
    gy0 = ifc.gy_o;
    mg0 = ifc.mag_o;
    wb = mk_win('{5, 0, 0, 0, 0, 0, 0, 60, 0});
    ifc.valid_i  = 1'b1;
    ifc.window_i = wb;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      tests++;
      if (ifc.valid_o !== 1'b1 || ifc.ready_o !== 1'b0 || ifc.gx_o !== gx0 ||
          ifc.gy_o !== gy0 || ifc.mag_o !== mg0) begin
        fails++;
        $display("FAIL bp hold %0d: valid=%b ready=%b gx=%0d gy=%0d mag=%0d",
                 n, ifc.valid_o, ifc.ready_o, ifc.gx_o, ifc.gy_o, ifc.mag_o);
      end
    end
    e = exp_q.pop_front();
    tests++;
    if ($signed(ifc.gx_o) !== e.gx || $signed(ifc.gy_o) !== e.gy ||
        int'(ifc.mag_o) !== e.mag) begin
      fails++;
      $display("FAIL bp result: got %0d/%0d/%0d want %0d/%0d/%0d",
               $signed(ifc.gx_o), $signed(ifc.gy_o), ifc.mag_o,
               e.gx, e.gy, e.mag);
    end
    ifc.ready_i = 1'b1;
    @(posedge clk);
    #1;
    ifc.ready_i = 1'b0;
    tests++;
    if (ifc.valid_o !== 1'b0 || ifc.ready_o !== 1'b1) begin
      fails++;
      $display("FAIL bp handshake: valid=%b ready=%b want 0/1",
               ifc.valid_o, ifc.ready_o);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(model(wb));
    ifc.valid_i = 1'b0;
    tests++;
    if (ifc.ready_o !== 1'b0) begin
      fails++;
      $display("FAIL bp accept: ready=%b want 0", ifc.ready_o);
    end
    wait_valid("bp_b", ok);
    if (!ok) return;
    e = exp_q.pop_front();
    tests++;
    if ($signed(ifc.gx_o) !== e.gx || $signed(ifc.gy_o) !== e.gy ||
        int'(ifc.mag_o) !== e.mag) begin
      fails++;
      $display("FAIL bp_b result: got %0d/%0d/%0d want %0d/%0d/%0d",
               $signed(ifc.gx_o), $signed(ifc.gy_o), ifc.mag_o,
               e.gx, e.gy, e.mag);
    end
    ifc.ready_i = 1'b1;
    @(posedge clk);
    #1;
    ifc.ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    send("rst_mid", mk_win('{7, 8, 9, 10, 11, 12, 13, 14, 15}),
         1'b1, acc, ok);
    if (!ok) return;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    tests++;
    if (ifc.valid_o !== 1'b0 || ifc.ready_o !== 1'b0 || ifc.gx_o !== '0 ||
        ifc.gy_o !== '0 || ifc.mag_o !== '0) begin
      fails++;
      $display("FAIL rst_mid: valid=%b ready=%b gx=%0d gy=%0d mag=%0d",
               ifc.valid_o, ifc.ready_o, ifc.gx_o, ifc.gy_o, ifc.mag_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (ifc.valid_o !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL rst_mid partial: valid_o=%b want 0", ifc.valid_o);
        break;
      end
    end
    run_one("after_rst", mk_win('{0, 0, 0, 50, 0, 0, 0, 0, 0}));
  endtask

  task automatic test_back_to_back();
    logic [9*PW-1:0] ws [4];
    int accs [4];
    ws[0] = mk_win('{1, 2, 3, 4, 5, 6, 7, 8, 9});
    ws[1] = mk_win('{90, 0, 0, 0, 0, 0, 0, 0, 0});
    ws[2] = mk_win('{0, 0, 0, 0, 0, 0, 0, 0, 33});
    ws[3] = mk_win('{0, 40, 0, 0, 0, 0, 0, 0, 0});
    ifc.ready_i = 1'b1;
    fork
      begin
        bit ok;
        for (int i = 0; i < 4; i++) begin
          send("b2b", ws[i], 1'b0, accs[i], ok);
          if (!ok) break;
          ifc.window_i = ws[(i + 1) % 4];
        end
        ifc.valid_i = 1'b0;
      end
      begin
        bit ok;
        res_t e;
        for (int j = 0; j < 4; j++) begin
          wait_valid("b2b", ok);
          if (!ok) break;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL b2b order %0d: result with empty queue", j);
          end else begin
            e = exp_q.pop_front();
            if ($signed(ifc.gx_o) !== e.gx || $signed(ifc.gy_o) !== e.gy ||
                int'(ifc.mag_o) !== e.mag) begin
              fails++;
              $display("FAIL b2b result %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                       j, $signed(ifc.gx_o), $signed(ifc.gy_o), ifc.mag_o,
                       e.gx, e.gy, e.mag);
            end
          end
          @(posedge clk);
          #1;
        end
      end
    join
    ifc.ready_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (accs[i] - accs[i-1] !== 11) begin
        fails++;
        $display("FAIL b2b spacing %0d: got %0d want 11",
                 i, accs[i] - accs[i-1]);
      end
    end
  endtask

  initial begin
    ifc.valid_i  = 1'b0;
    ifc.ready_i  = 1'b0;
    ifc.window_i = '0;
    test_reset();
    test_latency();
    test_patterns();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
